// File: rtl/peak_readout_pkg.sv
// peak_readout_pkg: widths, FSM state type and helpers for peak_readout.
// State encodings come from the shared constants.vh.
`include "constants.vh"
package peak_readout_pkg;

   localparam int RANK_W  = 4;
   localparam int OVC_W   = 8;
   localparam int FRAME_W = 16;

   typedef enum logic {
      IDLE = `PEAK_READOUT_IDLE,
      SEND = `PEAK_READOUT_SEND
   } state_e;

   function automatic logic [OVC_W-1:0] sat_inc(
      input logic [OVC_W-1:0] v
   );
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/constants.vh
// Shared widths and state encodings for the peak detect / readout blocks.
`ifndef CONSTANTS_VH
`define CONSTANTS_VH
`define VALUE_WIDTH 16
`define INDEX_WIDTH 12
`define PEAK_READOUT_IDLE 1'b0
`define PEAK_READOUT_SEND 1'b1
`endif

// File: rtl/peak_readout.sv
// peak_readout: snapshots per-stage peaks on frame_done_in and streams them
// as ranked records. PEAK_READOUT_FRAME_TAG_EN adds a 16-bit m_frame tag.
`include "constants.vh"
module peak_readout
   import peak_readout_pkg::*;
#(
   parameter int NUM_PEAKS = 3
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             frame_done_in,
   input  logic [NUM_PEAKS*`VALUE_WIDTH-1:0] peaks_in,
   input  logic [NUM_PEAKS*`INDEX_WIDTH-1:0] indexes_in,
   input  logic                             clr_overrun,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [`VALUE_WIDTH-1:0]          m_peak,
   output logic [`INDEX_WIDTH-1:0]          m_index,
   output logic [RANK_W-1:0]                m_rank,
   output logic                             m_last,
   output logic                             overrun_flag,
   output logic [OVC_W-1:0]                 overrun_count
`ifdef PEAK_READOUT_FRAME_TAG_EN
  ,output logic [FRAME_W-1:0]               m_frame
`endif
);

   localparam int VW = `VALUE_WIDTH;
   localparam int IW = `INDEX_WIDTH;
   localparam logic [RANK_W-1:0] LAST_RANK = RANK_W'(NUM_PEAKS - 1);

   state_e                  state_q, state_d;
   logic [RANK_W-1:0]       rank_q, rank_d, rank_nx;
   logic [NUM_PEAKS*VW-1:0] snap_pk_q, snap_pk_d;
   logic [NUM_PEAKS*IW-1:0] snap_ix_q, snap_ix_d;
   logic                    valid_q, valid_d;
   logic                    last_q, last_d;
   logic [VW-1:0]           peak_q, peak_d;
   logic [IW-1:0]           index_q, index_d;
   logic                    ovf_q, ovf_d;
   logic [OVC_W-1:0]        ovc_q, ovc_d;
   logic                    xfer, fin, cap, drop;

`ifdef PEAK_READOUT_FRAME_TAG_EN
   logic [FRAME_W-1:0]      fcnt_q, fcnt_d;
   logic [FRAME_W-1:0]      ftag_q, ftag_d;
`endif

   // A capture may coincide with the final beat, so back-to-back frames
   // stream without an idle bubble.
   always_comb begin
      xfer    = valid_q & m_ready;
      fin     = xfer & last_q;
      cap     = frame_done_in & ((state_q == IDLE) | fin);
      drop    = frame_done_in & ~cap;
      rank_nx = (rank_q == LAST_RANK) ? '0 : rank_q + 1'b1;

      state_d   = state_q;
      rank_d    = rank_q;
      snap_pk_d = snap_pk_q;
      snap_ix_d = snap_ix_q;
      valid_d   = valid_q;
      last_d    = last_q;
      peak_d    = peak_q;
      index_d   = index_q;

      if (cap) begin
         state_d   = SEND;
         rank_d    = '0;
         snap_pk_d = peaks_in;
         snap_ix_d = indexes_in;
         valid_d   = 1'b1;
         last_d    = (LAST_RANK == '0);
         peak_d    = peaks_in[VW-1:0];
         index_d   = indexes_in[IW-1:0];
      end else if (fin) begin
         state_d = IDLE;
         rank_d  = '0;
         valid_d = 1'b0;
         last_d  = 1'b0;
         peak_d  = snap_pk_q[VW-1:0];
         index_d = snap_ix_q[IW-1:0];
      end else if (xfer) begin
         rank_d  = rank_nx;
         last_d  = (rank_nx == LAST_RANK);
         peak_d  = snap_pk_q[VW*int'(rank_nx) +: VW];
         index_d = snap_ix_q[IW*int'(rank_nx) +: IW];
      end

      // Clear wins over a same-edge overrun.
      ovf_d = ovf_q;
      ovc_d = ovc_q;
      if (clr_overrun) begin
         ovf_d = 1'b0;
         ovc_d = '0;
      end else if (drop) begin
         ovf_d = 1'b1;
         ovc_d = sat_inc(ovc_q);
      end
   end

`ifdef PEAK_READOUT_FRAME_TAG_EN
   always_comb begin
      fcnt_d = fcnt_q;
      ftag_d = ftag_q;
      if (cap) begin
         ftag_d = fcnt_q;
         fcnt_d = fcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fcnt_q <= '0;
         ftag_q <= '0;
      end else begin
         fcnt_q <= fcnt_d;
         ftag_q <= ftag_d;
      end
   end

   assign m_frame = ftag_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         rank_q    <= '0;
         snap_pk_q <= '0;
         snap_ix_q <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         peak_q    <= '0;
         index_q   <= '0;
         ovf_q     <= 1'b0;
         ovc_q     <= '0;
      end else begin
         state_q   <= state_d;
         rank_q    <= rank_d;
         snap_pk_q <= snap_pk_d;
         snap_ix_q <= snap_ix_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         peak_q    <= peak_d;
         index_q   <= index_d;
         ovf_q     <= ovf_d;
         ovc_q     <= ovc_d;
      end
   end

   assign m_valid       = valid_q;
   assign m_peak        = peak_q;
   assign m_index       = index_q;
   assign m_rank        = rank_q;
   assign m_last        = last_q;
   assign overrun_flag  = ovf_q;
   assign overrun_count = ovc_q;

endmodule

// File: tb/tb_peak_readout.sv
// tb_peak_readout: directed and random checks of peak_readout against a
// queue-of-records model; a NUM_PEAKS=1 instance rides along.
`timescale 1ns/1ps
`include "constants.vh"
module tb_peak_readout;

   localparam int N  = 3;
   localparam int VW = `VALUE_WIDTH;
   localparam int IW = `INDEX_WIDTH;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            frame_done_in = 1'b0;
   logic            m_ready = 1'b0;
   logic            clr_overrun = 1'b0;
   logic [N*VW-1:0] peaks_in = '0;
   logic [N*IW-1:0] indexes_in = '0;
   logic            m_valid, m_last, overrun_flag;
   logic [VW-1:0]   m_peak;
   logic [IW-1:0]   m_index;
   logic [3:0]      m_rank;
   logic [7:0]      overrun_count;
   logic            v1, last1, ovf1;
   logic [VW-1:0]   peak1;
   logic [IW-1:0]   index1;
   logic [3:0]      rank1;
   logic [7:0]      ovc1;
`ifdef PEAK_READOUT_FRAME_TAG_EN
   logic [15:0]     m_frame, frame1;
`endif

   peak_readout #(.NUM_PEAKS(N)) dut (
      .clk(clk), .reset(reset), .frame_done_in(frame_done_in),
      .peaks_in(peaks_in), .indexes_in(indexes_in),
      .clr_overrun(clr_overrun), .m_valid(m_valid), .m_ready(m_ready),
      .m_peak(m_peak), .m_index(m_index), .m_rank(m_rank),
      .m_last(m_last), .overrun_flag(overrun_flag),
      .overrun_count(overrun_count)
`ifdef PEAK_READOUT_FRAME_TAG_EN
     ,.m_frame(m_frame)
`endif
   );

   peak_readout #(.NUM_PEAKS(1)) dut1 (
      .clk(clk), .reset(reset), .frame_done_in(frame_done_in),
      .peaks_in(peaks_in[VW-1:0]), .indexes_in(indexes_in[IW-1:0]),
      .clr_overrun(clr_overrun), .m_valid(v1), .m_ready(m_ready),
      .m_peak(peak1), .m_index(index1), .m_rank(rank1),
      .m_last(last1), .overrun_flag(ovf1), .overrun_count(ovc1)
`ifdef PEAK_READOUT_FRAME_TAG_EN
     ,.m_frame(frame1)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int peak;
      int idx;
      int rank;
      bit last;
      int frame;
   } rec_t;

   rec_t q[$];
   bit   mdl_ovf;
   int   mdl_ovc;
   int   mdl_fcnt;
   int   nvec = 0;
   int   nerr = 0;
   int   vcount = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      chk("m_valid", 64'(m_valid), 64'(q.size() != 0));
      if (m_valid) vcount++;
      if (q.size() != 0) begin
         chk("m_peak", 64'(m_peak), 64'(q[0].peak));
         chk("m_index", 64'(m_index), 64'(q[0].idx));
         chk("m_rank", 64'(m_rank), 64'(q[0].rank));
         chk("m_last", 64'(m_last), 64'(q[0].last));
`ifdef PEAK_READOUT_FRAME_TAG_EN
         chk("m_frame", 64'(m_frame), 64'(q[0].frame));
`endif
      end
      chk("overrun_flag", 64'(overrun_flag), 64'(mdl_ovf));
      chk("overrun_count", 64'(overrun_count), 64'(mdl_ovc));
      if (v1) begin
         chk("n1_last", 64'(last1), 64'(1));
         chk("n1_rank", 64'(rank1), 64'(0));
      end
   endtask

   task automatic model_step(bit fd, bit rdy, bit clr);
      bit busy, fin, drop;
      rec_t r;
      busy = (q.size() != 0);
      fin  = busy && rdy && (q.size() == 1);
      drop = 1'b0;
      if (busy && rdy) void'(q.pop_front());
      if (fd) begin
         if (!busy || fin) begin
            for (int i = 0; i < N; i++) begin
               r.peak  = int'(peaks_in[i*VW +: VW]);
               r.idx   = int'(indexes_in[i*IW +: IW]);
               r.rank  = i;
               r.last  = (i == N - 1);
               r.frame = mdl_fcnt;
               q.push_back(r);
            end
            mdl_fcnt = (mdl_fcnt + 1) % 65536;
         end else begin
            drop = 1'b1;
         end
      end
      if (clr) begin
         mdl_ovf = 1'b0;
         mdl_ovc = 0;
      end else if (drop) begin
         mdl_ovf = 1'b1;
         if (mdl_ovc < 255) mdl_ovc++;
      end
   endtask

   task automatic cycle(bit fd, bit rdy, bit clr);
      frame_done_in = fd;
      m_ready       = rdy;
      clr_overrun   = clr;
      @(negedge clk);
      compare_model();
      model_step(fd, rdy, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      q.delete();
      mdl_ovf  = 1'b0;
      mdl_ovc  = 0;
      mdl_fcnt = 0;
   endtask

   task automatic do_reset();
      frame_done_in = 1'b0;
      m_ready       = 1'b0;
      clr_overrun   = 1'b0;
      reset         = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic set_frame(int p0, int p1, int p2,
                            int i0, int i1, int i2);
      peaks_in   = {VW'(p2), VW'(p1), VW'(p0)};
      indexes_in = {IW'(i2), IW'(i1), IW'(i0)};
   endtask

   initial begin
      model_reset();
      #1 reset = 1'b1;
      #1;
      chk("rst_valid", 64'(m_valid), 64'(0));
      chk("rst_last", 64'(m_last), 64'(0));
      chk("rst_peak", 64'(m_peak), 64'(0));
      chk("rst_index", 64'(m_index), 64'(0));
      chk("rst_rank", 64'(m_rank), 64'(0));
      chk("rst_ovf", 64'(overrun_flag), 64'(0));
      chk("rst_ovc", 64'(overrun_count), 64'(0));
      @(posedge clk);
      #1 reset = 1'b0;

      // three beats with m_ready held high
      set_frame(40, 30, 20, 'h105, 'h10A, 'h1F0);
      vcount = 0;
      cycle(1, 1, 0);
      chk("b0_valid", 64'(m_valid), 64'(1));
      chk("b0_peak", 64'(m_peak), 64'(40));
      chk("b0_index", 64'(m_index), 64'('h105));
      chk("b0_rank", 64'(m_rank), 64'(0));
      chk("b0_last", 64'(m_last), 64'(0));
      cycle(0, 1, 0);
      chk("b1_peak", 64'(m_peak), 64'(30));
      chk("b1_index", 64'(m_index), 64'('h10A));
      chk("b1_rank", 64'(m_rank), 64'(1));
      cycle(0, 1, 0);
      chk("b2_peak", 64'(m_peak), 64'(20));
      chk("b2_index", 64'(m_index), 64'('h1F0));
      chk("b2_last", 64'(m_last), 64'(1));
      for (int i = 0; i < 3; i++) cycle(0, 1, 0);
      chk("valid_cycles", 64'(vcount), 64'(3));

      // stalled downstream
      cycle(1, 1, 0);
      begin
         bit pat [6] = '{1, 0, 0, 1, 0, 1};
         for (int i = 0; i < 6; i++) cycle(0, pat[i], 0);
      end
      chk("stall_done", 64'(m_valid), 64'(0));

      // overrun while stalled at rank 1, then saturation and clear
      cycle(1, 1, 0);
      cycle(0, 1, 0);
      set_frame(9, 8, 7, 1, 2, 3);
      cycle(1, 0, 0);
      chk("ovr_peak", 64'(m_peak), 64'(30));
      chk("ovr_rank", 64'(m_rank), 64'(1));
      chk("ovr_flag", 64'(overrun_flag), 64'(1));
      chk("ovr_cnt1", 64'(overrun_count), 64'(1));
      for (int i = 0; i < 300; i++) cycle(1, 0, 0);
      chk("ovr_sat", 64'(overrun_count), 64'(255));
      chk("ovr_hold", 64'(m_peak), 64'(30));
      cycle(1, 0, 1);
      chk("clr_flag", 64'(overrun_flag), 64'(0));
      chk("clr_cnt", 64'(overrun_count), 64'(0));
      for (int i = 0; i < 3; i++) cycle(0, 1, 0);

      // capture on the final beat: no bubble, no overrun
      set_frame(40, 30, 20, 'h105, 'h10A, 'h1F0);
      cycle(1, 1, 0);
      cycle(0, 1, 0);
      cycle(0, 1, 0);
      set_frame(77, 66, 55, 'h011, 'h022, 'h033);
      cycle(1, 1, 0);
      chk("b2b_valid", 64'(m_valid), 64'(1));
      chk("b2b_rank", 64'(m_rank), 64'(0));
      chk("b2b_peak", 64'(m_peak), 64'(77));
      chk("b2b_ovf", 64'(overrun_flag), 64'(0));
      for (int i = 0; i < 4; i++) cycle(0, 1, 0);

      // asynchronous reset mid-frame
      cycle(1, 1, 0);
      cycle(0, 1, 0);
      cycle(1, 0, 0);
      #2 reset = 1'b1;
      #1;
      chk("arst_valid", 64'(m_valid), 64'(0));
      chk("arst_peak", 64'(m_peak), 64'(0));
      chk("arst_index", 64'(m_index), 64'(0));
      chk("arst_rank", 64'(m_rank), 64'(0));
      chk("arst_ovf", 64'(overrun_flag), 64'(0));
      chk("arst_ovc", 64'(overrun_count), 64'(0));
      frame_done_in = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) cycle(0, 1, 0);
      chk("arst_quiet", 64'(m_valid), 64'(0));

`ifdef PEAK_READOUT_FRAME_TAG_EN
      for (int f = 0; f < 4; f++) begin
         set_frame(f + 1, f + 2, f + 3, f, f, f);
         cycle(1, 1, 0);
         chk("frame_tag", 64'(m_frame), 64'(f));
         if (f == 1) cycle(1, 0, 0);
         for (int i = 0; i < 3; i++) cycle(0, 1, 0);
      end
`endif

      // randomized traffic
      for (int it = 0; it < 2000; it++) begin
         for (int i = 0; i < N; i++) begin
            peaks_in[i*VW +: VW]   = VW'($urandom);
            indexes_in[i*IW +: IW] = IW'($urandom);
         end
         cycle(($urandom % 4) == 0, ($urandom % 3) != 0,
               ($urandom % 40) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/peak_readout.md
PEAK_READOUT -- requirements
Module: peak_readout

Interface
REQ-001 SHALL have parameter NUM_PEAKS, default 3: number of peak-detect stages read out, range 1..16.
REQ-002 SHALL take value and index widths from `VALUE_WIDTH and `INDEX_WIDTH in constants.vh; these are not parameters.
REQ-003 SHALL have ports, in this order:
clk  in  1  single clock; all logic on posedge.
reset  in  1  asynchronous, active-high.
frame_done_in  in  1  one-cycle pulse; all stage final peaks and indexes are stable this cycle.
peaks_in  in  NUM_PEAKS*`VALUE_WIDTH  stage held_peak_final values concatenated; stage 0 in the LSBs.
indexes_in  in  NUM_PEAKS*`INDEX_WIDTH  stage held_index_final values, same packing.
clr_overrun  in  1  clears overrun_flag and overrun_count.
m_valid  out  1  output record valid.
m_ready  in  1  downstream accept.
m_peak  out  `VALUE_WIDTH  record peak value.
m_index  out  `INDEX_WIDTH  record index.
m_rank  out  4  stage number of the record, 0..NUM_PEAKS-1.
m_last  out  1  final record of the frame.
overrun_flag  out  1  sticky; a frame was dropped.
overrun_count  out  8  count of dropped frames, saturating.

Function
REQ-004 SHALL implement a two-state FSM, IDLE and SEND; reset state is IDLE.
REQ-005 In IDLE, frame_done_in high SHALL capture peaks_in and indexes_in into a snapshot register, set rank to 0 and go to SEND on the same edge.
REQ-006 m_valid SHALL be high in SEND and low in IDLE; latency from a frame_done_in edge to m_valid high is one cycle.
REQ-007 m_peak, m_index and m_rank SHALL present the snapshot entry selected by rank; this entry is registered and does not change while m_valid=1 and m_ready=0.
REQ-008 A beat is transferred on an edge where m_valid and m_ready are both high; m_valid SHALL NOT depend combinationally on m_ready.
REQ-009 On a transfer with rank < NUM_PEAKS-1, rank SHALL increment by 1.
REQ-010 m_last SHALL be 1 only when rank = NUM_PEAKS-1; a transfer with m_last=1 SHALL return the FSM to IDLE.
REQ-011 frame_done_in in SEND SHALL be dropped: the snapshot is unchanged, overrun_flag is set, overrun_count increments and saturates at 255.
REQ-012 frame_done_in on the same edge as the final transfer SHALL NOT count as an overrun; it is captured and the FSM stays in SEND with rank 0, so there is no idle bubble.
REQ-013 clr_overrun SHALL clear overrun_flag and overrun_count on the next edge.
REQ-014 clr_overrun together with an overrun event on the same edge: the clear SHALL take priority, and the result is flag 0, count 0.
REQ-015 With NUM_PEAKS=1, every record SHALL have m_last=1 and m_rank=0.

Reset
REQ-016 Asserting reset SHALL immediately force: FSM IDLE, rank 0, m_valid 0, m_last 0, m_peak 0, m_index 0, m_rank 0, overrun_flag 0, overrun_count 0, snapshot 0.
REQ-017 Reset in SEND SHALL abandon the frame in progress; no further records of that frame are emitted after reset is released.

Configuration
REQ-018 With macro PEAK_READOUT_FRAME_TAG_EN defined, SHALL add output port m_frame (out, 16 bits): a frame number that increments on every captured frame (dropped frames excluded), wraps from 65535 to 0, is reset to 0, and is constant across all records of one frame.
REQ-019 Without PEAK_READOUT_FRAME_TAG_EN, port m_frame and its counter SHALL NOT exist; all other behaviour is identical.

Structure
REQ-020 `VALUE_WIDTH and `INDEX_WIDTH SHALL come from the shared constants.vh; the FSM state encodings SHALL be added there as PEAK_READOUT_IDLE and PEAK_READOUT_SEND.
REQ-021 SHALL be a single module with no sub-modules; the snapshot mux is inline.

Verification
REQ-022 NUM_PEAKS=3; peaks 40/30/20 with indexes 0x105/0x10A/0x1F0; m_ready held 1 -> three consecutive beats, rank 0,1,2, m_last on rank 2, m_valid high exactly 3 cycles.
REQ-023 Same frame with m_ready toggling 1,0,0,1,0,1 -> data held stable while stalled, still exactly 3 beats in order.
REQ-024 Second frame_done_in while rank=1 and m_ready=0 -> first frame output unchanged, overrun_flag=1, overrun_count=1; 300 such drops -> count holds at 255.
REQ-025 frame_done_in on the same edge as the rank-2 transfer -> next cycle m_valid=1, rank 0, new data, overrun_flag still 0.
REQ-026 Reset asserted mid-frame at rank 1 -> m_valid drops asynchronously, all outputs 0; after release, no beats until the next frame_done_in.
REQ-027 With PEAK_READOUT_FRAME_TAG_EN defined, four frames -> m_frame reads 0,1,2,3, and one dropped frame does not advance it.
